// File: rtl/fifo_pkg.sv
// fifo_pkg
//   Shared constants and types for the parameterised FIFO.
//   FIFO_WIDTH_DEF / FIFO_DEPTH_DEF : default data width and entry count.
//   fifo_status_t                   : registered status/error flag bundle.
package fifo_pkg;

  localparam int FIFO_WIDTH_DEF = 8;
  localparam int FIFO_DEPTH_DEF = 4096;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram
//   Simple dual-port storage: one synchronous write port and one registered
//   read port. No reset on the array or on the read register.
//   clk   : clock, rising edge
//   we    : write enable, stores wdata at waddr
//   waddr : write address
//   wdata : write data
//   re    : read enable, loads rdata from raddr
//   raddr : read address
//   rdata : registered read data, holds when re=0
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Read-before-write: a same-edge read and write of one address (full FIFO
  // with simultaneous push/pop) returns the old entry.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/param_fifo.sv
// param_fifo
//   Synchronous FIFO of DEPTH entries (all usable), one-cycle read latency,
//   registered status and sticky error flags.
//   clk, rst       : clock (rising edge), synchronous active-high reset
//   flush          : discard contents; overrides wr_en/rd_en
//   wr_d, wr_en    : write data and request
//   rd_en          : read request
//   rd_d, rd_valid : popped data and its one-cycle valid strobe
//   full, empty, almost_full, almost_empty : registered occupancy status
//   count          : registered occupancy 0..DEPTH
//   overflow, underflow : sticky, cleared only by rst
module param_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH    = FIFO_WIDTH_DEF,
  parameter int DEPTH    = FIFO_DEPTH_DEF,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wr_d,
  input  logic                   wr_en,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_d,
  output logic                   rd_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  fifo_status_t     status_q, status_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_seen_q, rd_seen_d;
  logic             rd_acc, wr_acc;
  logic             ram_we, ram_re;
  logic [WIDTH-1:0] ram_rdata;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    status_d   = status_q;
    rd_valid_d = 1'b0;
    rd_seen_d  = rd_seen_q;
    ram_we     = 1'b0;
    ram_re     = 1'b0;

    rd_acc = rd_en && !status_q.empty;
    // A pop frees a slot in the same cycle, so a full FIFO still takes a push.
    wr_acc = wr_en && (!status_q.full || rd_acc);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      ram_we = wr_acc && !rst;
      ram_re = rd_acc && !rst;
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr_d   = rd_ptr_q + AW'(1);
        rd_valid_d = 1'b1;
        rd_seen_d  = 1'b1;
      end
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (wr_en && !wr_acc) begin
        status_d.overflow = 1'b1;
      end
      if (rd_en && !rd_acc) begin
        status_d.underflow = 1'b1;
      end
    end

    status_d.full         = (count_d == CW'(DEPTH));
    status_d.empty        = (count_d == '0);
    status_d.almost_full  = (count_d >= CW'(AF_LEVEL));
    status_d.almost_empty = (count_d <= CW'(AE_LEVEL));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q              <= '0;
      rd_ptr_q              <= '0;
      count_q               <= '0;
      status_q              <= '0;
      status_q.empty        <= 1'b1;
      status_q.almost_empty <= 1'b1;
      rd_valid_q            <= 1'b0;
      rd_seen_q             <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      status_q   <= status_d;
      rd_valid_q <= rd_valid_d;
      rd_seen_q  <= rd_seen_d;
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata (wr_d),
    .re    (ram_re),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  // The RAM read register has no reset; rd_d reads as 0 until the first pop
  // after reset, and afterwards follows the RAM register, which only loads on
  // an accepted pop and therefore holds across idle cycles and flush.
  assign rd_d         = rd_seen_q ? ram_rdata : '0;
  assign rd_valid     = rd_valid_q;
  assign count        = count_q;
  assign full         = status_q.full;
  assign empty        = status_q.empty;
  assign almost_full  = status_q.almost_full;
  assign almost_empty = status_q.almost_empty;
  assign overflow     = status_q.overflow;
  assign underflow    = status_q.underflow;

endmodule
